text_writer_ctrl: RTL and testbench
===================================

TEXT_WRITER_CTRL -- requirements
Module: text_writer_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 80, meaning text columns per row.
REQ-002 SHALL have parameter ROWS, default 30, meaning text rows per screen.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port fifo_empty  input  1  byte FIFO has no data.
REQ-006 SHALL have port fifo_data  input  8  FIFO read data, valid the cycle after fifo_rd_en.
REQ-007 SHALL have port fifo_rd_en  output  1  pop one byte from the FIFO.
REQ-008 SHALL have port vram_we  output  1  character RAM write request.
REQ-009 SHALL have port vram_addr  output  12  cell address, row*COLS+col.
REQ-010 SHALL have port vram_data  output  8  character code to write.
REQ-011 SHALL have port vram_ready  input  1  write accepted this cycle when vram_we=1.
REQ-012 SHALL have port cursor_col  output  7  current column, 0..COLS-1.
REQ-013 SHALL have port cursor_row  output  5  current row, 0..ROWS-1.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL implement states IDLE, FETCH, LATCH, WRITE, CLR_ROW and CLR_ALL.
REQ-016 SHALL go IDLE->FETCH when fifo_empty=0, and SHALL assert fifo_rd_en for exactly the one FETCH cycle.
REQ-017 SHALL go FETCH->LATCH unconditionally, capturing fifo_data at the end of the LATCH cycle, then decode the byte.
REQ-018 SHALL treat bytes 0x20..0x7E as printable: enter WRITE with vram_addr at the cursor and vram_data equal to the byte.
REQ-019 SHALL hold vram_we, vram_addr and vram_data stable in WRITE/CLR_* until a cycle with vram_ready=1; the write completes in that cycle.
REQ-020 SHALL, after a printable write, advance the column; at col=COLS-1 it SHALL set col=0 and perform a row advance.
REQ-021 SHALL decode 0x0A (LF) as col=0 plus row advance, with no character write.
REQ-022 SHALL decode 0x0D (CR) as col=0, with no write, and return to IDLE.
REQ-023 SHALL decode 0x08 (BS) as col=col-1 when col>0 (no change at col=0), with no write.
REQ-024 SHALL decode 0x0C (FF) as a cursor reset to (0,0) followed by CLR_ALL.
REQ-025 SHALL discard all other bytes and return to IDLE.
REQ-026 SHALL perform a row advance as row=(row==ROWS-1)?0:row+1, then enter CLR_ROW for the new row.
REQ-027 SHALL in CLR_ROW write 0x20 to the COLS cells of the cursor row, col ascending, then return to IDLE.
REQ-028 SHALL in CLR_ALL write 0x20 to addresses 0..COLS*ROWS-1 ascending, then return to IDLE.
REQ-029 SHALL keep fifo_rd_en=0 in every state except FETCH, so no pops occur during writes or clears.
REQ-030 SHALL have a best-case latency of 4 cycles from fifo_empty falling to vram_we for a printable byte with vram_ready held high.
REQ-031 SHALL drive vram_we=0 in IDLE, FETCH and LATCH.

Reset
REQ-032 SHALL, while rst=0 at a clock edge, set fifo_rd_en=0, vram_we=0, vram_addr=0, vram_data=0, cursor=(0,0) and busy=1.
REQ-033 SHALL enter CLR_ALL on the first edge with rst=1, so the screen is blanked after every reset.
REQ-034 SHALL, on reset asserted mid-operation, abort immediately, drop any in-flight byte, and leave the FIFO untouched.

Structure
REQ-035 SHALL place COLS/ROWS defaults, control codes (0x08, 0x0A, 0x0C, 0x0D, 0x20) and the state enum in shared package text_pkg.
REQ-036 SHALL place the column/row counter, with advance, wrap and BS decrement, in one sub-module, text_cursor.

Verification
REQ-037 SHALL check reset release with vram_ready=1: 2400 writes of 0x20 at addr 0..2399, busy falls after 2400 writes, cursor=(0,0).
REQ-038 SHALL check FIFO bytes "A","B" with vram_ready=1: writes (addr 0, 0x41) and (addr 1, 0x42), cursor_col=2, exactly two fifo_rd_en pulses.
REQ-039 SHALL check 80 printable bytes at row 29: the last byte goes to addr 2399, then cursor=(0,0) and addr 0..79 are written 0x20.
REQ-040 SHALL check vram_ready=0 for 10 cycles during WRITE: vram_we/addr/data stay constant and fifo_rd_en stays 0 despite fifo_empty=0.
REQ-041 SHALL check bytes 0x0D, 0x08 at col 0, and 0x07: no writes occur, cursor is unchanged, and three pops occur.
REQ-042 SHALL check rst=0 during CLR_ALL at addr 500: vram_we is 0 the next cycle, and a full clear from addr 0 restarts after release.

Source files
------------

// File: rtl/text_pkg.sv
// Shared constants, state/command enums and the cell address helper for the
// text writer controller.
package text_pkg;

  localparam int COLS_DEF = 80;
  localparam int ROWS_DEF = 30;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_TILDE = 8'h7E;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_LATCH   = 3'd2,
    ST_WRITE   = 3'd3,
    ST_CLR_ROW = 3'd4,
    ST_CLR_ALL = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CUR_NONE = 3'd0,
    CUR_HOME = 3'd1,
    CUR_CR   = 3'd2,
    CUR_BS   = 3'd3,
    CUR_ADV  = 3'd4,
    CUR_LF   = 3'd5
  } cur_cmd_e;

  function automatic logic [11:0] cell_addr(input logic [4:0] row,
                                            input logic [6:0] col,
                                            input int cols);
    logic [11:0] r12;
    logic [11:0] c12;
    r12 = {7'd0, row};
    c12 = {5'd0, col};
    return (r12 * 12'(cols)) + c12;
  endfunction

endpackage

// File: rtl/text_cursor.sv
// Cursor column/row counter: home, carriage return, backspace, column advance
// with wrap into a row advance, and line feed.
module text_cursor
  import text_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  cur_cmd_e   cmd,
  output logic [6:0] col_q,
  output logic [4:0] row_q,
  output logic [4:0] row_inc,
  output logic       col_last
);
  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  logic [6:0] col_d;
  logic [4:0] row_d;

  // row_inc and col_last depend only on the current cursor, never on cmd
  always_comb begin
    row_inc  = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;
    col_last = (col_q == LAST_COL);
    col_d    = col_q;
    row_d    = row_q;
    case (cmd)
      CUR_HOME: begin
        col_d = 7'd0;
        row_d = 5'd0;
      end
      CUR_CR: col_d = 7'd0;
      CUR_BS: begin
        if (col_q != 7'd0) begin
          col_d = col_q - 7'd1;
        end else begin
          col_d = col_q;
        end
      end
      CUR_ADV: begin
        if (col_last) begin
          col_d = 7'd0;
          row_d = row_inc;
        end else begin
          col_d = col_q + 7'd1;
        end
      end
      CUR_LF: begin
        col_d = 7'd0;
        row_d = row_inc;
      end
      default: begin
        col_d = col_q;
        row_d = row_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      col_q <= 7'd0;
      row_q <= 5'd0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/text_writer_ctrl.sv
// Pops bytes from a FIFO, writes printable characters into character RAM at
// the cursor, interprets control codes and blanks rows / the whole screen.
module text_writer_ctrl
  import text_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_data,
  output logic        fifo_rd_en,
  output logic        vram_we,
  output logic [11:0] vram_addr,
  output logic [7:0]  vram_data,
  input  logic        vram_ready,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        busy
);
  localparam logic [11:0] LAST_CELL = 12'(COLS * ROWS - 1);
  localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);

  state_e      state_q, state_d;
  logic        rd_en_q, rd_en_d;
  logic        we_q, we_d;
  logic [11:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        busy_q, busy_d;
  cur_cmd_e    cur_cmd;
  logic [6:0]  col_q;
  logic [4:0]  row_q;
  logic [4:0]  row_inc;
  logic        col_last;
  logic        printable;
  logic [11:0] clr_last;

  text_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
    .clk      (clk),
    .rst      (rst),
    .cmd      (cur_cmd),
    .col_q    (col_q),
    .row_q    (row_q),
    .row_inc  (row_inc),
    .col_last (col_last)
  );

  always_comb begin
    state_d   = state_q;
    rd_en_d   = 1'b0;
    we_d      = we_q;
    addr_d    = addr_q;
    data_d    = data_q;
    cur_cmd   = CUR_NONE;
    printable = (fifo_data >= CH_SPACE) && (fifo_data <= CH_TILDE);
    if (state_q == ST_CLR_ROW) begin
      clr_last = cell_addr(row_q, LAST_COL, COLS);
    end else begin
      clr_last = LAST_CELL;
    end
    case (state_q)
      ST_IDLE: begin
        we_d = 1'b0;
        if (!fifo_empty) begin
          state_d = ST_FETCH;
          rd_en_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        we_d    = 1'b0;
        state_d = ST_LATCH;
      end
      ST_LATCH: begin
        we_d = 1'b0;
        if (printable) begin
          state_d = ST_WRITE;
          we_d    = 1'b1;
          addr_d  = cell_addr(row_q, col_q, COLS);
          data_d  = fifo_data;
        end else begin
          state_d = ST_IDLE;
          case (fifo_data)
            CH_LF: begin
              cur_cmd = CUR_LF;
              state_d = ST_CLR_ROW;
              we_d    = 1'b1;
              addr_d  = cell_addr(row_inc, 7'd0, COLS);
              data_d  = CH_SPACE;
            end
            CH_CR: cur_cmd = CUR_CR;
            CH_BS: cur_cmd = CUR_BS;
            CH_FF: begin
              cur_cmd = CUR_HOME;
              state_d = ST_CLR_ALL;
              we_d    = 1'b1;
              addr_d  = 12'd0;
              data_d  = CH_SPACE;
            end
            default: cur_cmd = CUR_NONE;
          endcase
        end
      end
      ST_WRITE: begin
        if (vram_ready) begin
          cur_cmd = CUR_ADV;
          if (col_last) begin
            state_d = ST_CLR_ROW;
            addr_d  = cell_addr(row_inc, 7'd0, COLS);
            data_d  = CH_SPACE;
          end else begin
            state_d = ST_IDLE;
            we_d    = 1'b0;
          end
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_CLR_ROW, ST_CLR_ALL: begin
        // A clear state with no write pending only occurs right after reset
        if (!we_q) begin
          we_d   = 1'b1;
          addr_d = (state_q == ST_CLR_ALL) ? 12'd0 : cell_addr(row_q, 7'd0, COLS);
          data_d = CH_SPACE;
        end else if (vram_ready) begin
          if (addr_q == clr_last) begin
            state_d = ST_IDLE;
            we_d    = 1'b0;
          end else begin
            addr_d = addr_q + 12'd1;
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        we_d    = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_CLR_ALL;
      rd_en_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 12'd0;
      data_q  <= 8'd0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      rd_en_q <= rd_en_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign vram_we    = we_q;
  assign vram_addr  = addr_q;
  assign vram_data  = data_q;
  assign busy       = busy_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;

endmodule

// File: tb/tb_text_writer_ctrl.sv
// Scoreboard bench for text_writer_ctrl: directed byte streams with
// hand-computed expected RAM writes, checked by an independent monitor.
module tb_text_writer_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_data = 8'h00;
  logic        fifo_rd_en;
  logic        vram_we;
  logic [11:0] vram_addr;
  logic [7:0]  vram_data;
  logic        vram_ready = 1'b1;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;

  int total = 0;
  int bad = 0;
  int writes = 0;
  int pops = 0;
  logic [7:0]  fq[$];
  logic [19:0] sb[$];
  logic [19:0] mon_e;

  text_writer_ctrl #(.COLS(80), .ROWS(30)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .vram_we    (vram_we),
    .vram_addr  (vram_addr),
    .vram_data  (vram_data),
    .vram_ready (vram_ready),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // FIFO model: data appears the cycle after a pop request
  always @(posedge clk) begin
    if (fifo_rd_en && fq.size() > 0) begin
      fifo_data <= fq.pop_front();
      pops++;
    end
  end

  always begin
    @(negedge clk);
    #2;
    fifo_empty = (fq.size() == 0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a write is accepted at the next edge when we and ready are high
  always begin
    @(negedge clk);
    #1;
    if (rst && vram_we && vram_ready) begin
      writes++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: addr=%0d data=%02h, none expected", vram_addr, vram_data);
      end else begin
        mon_e = sb.pop_front();
        chk("vram_write", {12'd0, vram_addr, vram_data}, {12'd0, mon_e});
      end
    end
  end

  task automatic exp_w(input int a, input logic [7:0] d);
    sb.push_back({12'(a), d});
  endtask

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    fq.push_back(b);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while ((fq.size() != 0 || busy) && n < budget);
    if (n >= budget) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, n);
    end
    chk({name, "_drained"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int n;
    int w0;
    int p0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_we", {31'd0, vram_we}, 32'd0);
    chk("rst_addr", {20'd0, vram_addr}, 32'd0);
    chk("rst_data", {24'd0, vram_data}, 32'd0);
    chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_col", {25'd0, cursor_col}, 32'd0);
    chk("rst_row", {27'd0, cursor_row}, 32'd0);

    // Release: full screen blank
    for (int i = 0; i < 2400; i++) exp_w(i, 8'h20);
    w0 = writes;
    rst = 1'b1;
    wait_idle("boot_clear", 3000);
    chk("boot_writes", 32'(writes - w0), 32'd2400);
    chk("boot_busy", {31'd0, busy}, 32'd0);
    chk("boot_col", {25'd0, cursor_col}, 32'd0);
    chk("boot_row", {27'd0, cursor_row}, 32'd0);

    // CR, BS at col 0, BEL: no writes, no cursor change, three pops
    w0 = writes;
    p0 = pops;
    push_byte(8'h0D);
    push_byte(8'h08);
    push_byte(8'h07);
    wait_idle("ctrl", 100);
    chk("ctrl_writes", 32'(writes - w0), 32'd0);
    chk("ctrl_pops", 32'(pops - p0), 32'd3);
    chk("ctrl_col", {25'd0, cursor_col}, 32'd0);
    chk("ctrl_row", {27'd0, cursor_row}, 32'd0);

    // "A","B" with latency measurement on the first byte
    p0 = pops;
    exp_w(0, 8'h41);
    exp_w(1, 8'h42);
    push_byte(8'h41);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!vram_we && n < 10);
    chk("latency_le4", {31'd0, (n <= 4)}, 32'd1);
    push_byte(8'h42);
    wait_idle("ab", 100);
    chk("ab_col", {25'd0, cursor_col}, 32'd2);
    chk("ab_row", {27'd0, cursor_row}, 32'd0);
    chk("ab_pops", 32'(pops - p0), 32'd2);

    // Stall in WRITE with another byte waiting in the FIFO
    @(negedge clk);
    vram_ready = 1'b0;
    exp_w(2, 8'h43);
    push_byte(8'h43);
    push_byte(8'h07);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!vram_we && n < 20);
    chk("stall_addr", {20'd0, vram_addr}, 32'd2);
    chk("stall_data", {24'd0, vram_data}, 32'h43);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("stall_we", {31'd0, vram_we}, 32'd1);
      chk("stall_hold", {12'd0, vram_addr, vram_data}, {12'd0, 12'd2, 8'h43});
      chk("stall_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    end
    @(negedge clk);
    vram_ready = 1'b1;
    wait_idle("stall", 100);
    chk("stall_col", {25'd0, cursor_col}, 32'd3);

    // 29 line feeds: each clears the new row
    for (int r = 1; r < 30; r++) begin
      for (int c = 0; c < 80; c++) exp_w(r * 80 + c, 8'h20);
    end
    for (int r = 1; r < 30; r++) push_byte(8'h0A);
    wait_idle("lf", 4000);
    chk("lf_col", {25'd0, cursor_col}, 32'd0);
    chk("lf_row", {27'd0, cursor_row}, 32'd29);

    // 80 printables on the last row wrap to row 0 and clear it
    for (int i = 0; i < 80; i++) exp_w(2320 + i, 8'h61 + 8'(i % 26));
    for (int c = 0; c < 80; c++) exp_w(c, 8'h20);
    for (int i = 0; i < 80; i++) push_byte(8'h61 + 8'(i % 26));
    wait_idle("wrap", 2000);
    chk("wrap_col", {25'd0, cursor_col}, 32'd0);
    chk("wrap_row", {27'd0, cursor_row}, 32'd0);

    // Form feed, then reset in the middle of the clear
    for (int i = 0; i < 500; i++) exp_w(i, 8'h20);
    push_byte(8'h0C);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(vram_we && vram_addr == 12'd500) && n < 1000);
    chk("ff_reached_500", {31'd0, (n < 1000)}, 32'd1);
    rst = 1'b0;
    vram_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("abort_we", {31'd0, vram_we}, 32'd0);
    chk("abort_addr", {20'd0, vram_addr}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd1);
    chk("abort_drained", 32'(sb.size()), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 2400; i++) exp_w(i, 8'h20);
    rst = 1'b1;
    vram_ready = 1'b1;
    wait_idle("reclear", 3000);
    chk("reclear_col", {25'd0, cursor_col}, 32'd0);
    chk("reclear_row", {27'd0, cursor_row}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
